serial_capture_fifo: RTL and testbench
======================================

# serial_capture_fifo

Parametrised serial-to-parallel capture buffer between the Raspberry Pi serial link and the downstream audio datapath. It samples an externally clocked bit stream (`sclk`/`sdata`) in the single `clk` domain, assembles `WORD_W`-bit words, queues them in a `DEPTH`-entry FIFO and raises `irq` when the fill level reaches a programmable threshold. It adds a single-clock design, reset, full/empty protection, sticky error flags, selectable bit order and flush.

## Interface
- `WORD_W`, 24, bits per captured word (2..32)
- `DEPTH`, 64, FIFO entries; power of two, >= 4
- `IRQ_THRESH`, 32, level at or above which `irq` asserts (1..DEPTH)
- `LSB_FIRST`, 1, 1: first received bit lands in bit 0; 0: first bit lands in bit `WORD_W-1`
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sclk`  in  1  serial bit clock from RPi, asynchronous to `clk`, each high and low phase >= 3 `clk` periods
- `sdata`  in  1  serial data, stable around `sclk` rising edge
- `enable`  in  1  capture enable, synchronous to `clk`
- `clear`  in  1  synchronous flush pulse
- `rd_req`  in  1  read strobe from RPi, asynchronous; one pop per rising edge
- `rd_data`  out  WORD_W  last popped word
- `rd_valid`  out  1  one-cycle pulse when `rd_data` updates
- `level`  out  $clog2(DEPTH)+1  current fill level, 0..DEPTH
- `irq`  out  1  `enable && level >= IRQ_THRESH`, registered
- `overflow`  out  1  sticky: a word was dropped on full
- `underflow`  out  1  sticky: read attempted on empty

## Operation
- `sclk`, `sdata`, `rd_req` each pass a 2-flop synchroniser; `sclk` and `rd_req` feed a rising-edge detector (third flop); `sdata` takes the same 2-flop path so it stays aligned with the detected `sclk` edge.
- On `sclk` edge with `enable` high: shift the synced bit into the assembler at position `bit_cnt` (or `WORD_W-1-bit_cnt` when `LSB_FIRST=0`); `bit_cnt` increments; on `bit_cnt == WORD_W-1` the completed word (including this bit) is pushed and `bit_cnt` returns to 0.
- `enable` low: `bit_cnt` held at 0, partial word discarded; FIFO contents, flags and reads unaffected; `irq` forced 0.
- Push when full with no simultaneous pop: word dropped, `overflow` set. Push and pop in the same cycle: both performed, level unchanged, including when full.
- `rd_req` edge, FIFO non-empty: `rd_data <= mem[rd_ptr]`, `rd_ptr++`, `rd_valid` pulses. Empty: `rd_data` holds, no pulse, `underflow` set.
- Pointers are `$clog2(DEPTH)+1` bits, wrap naturally; `level = wr_ptr - rd_ptr` (modulo arithmetic); full when `level == DEPTH`.
- `clear`: pointers, `bit_cnt`, assembler, `overflow`, `underflow` zeroed next cycle; `rd_data` retained; `clear` takes priority over a same-cycle push/pop.

## Timing
- Reset values: `rd_data` 0, `rd_valid` 0, `level` 0, `irq` 0, `overflow` 0, `underflow` 0; synchroniser flops 0. Reset mid-word discards the partial word and all FIFO contents.
- `sclk` rising at pin to bit captured: 3–4 `clk` cycles. Last-bit capture to `level` increment: same edge (`level` registered with pointers). `level` to `irq`: +1 cycle.
- `rd_req` rising at pin to `rd_valid`/`rd_data`: 3–4 `clk` cycles; `level` decrements the same cycle.
- `irq` deasserts one cycle after `level` falls below `IRQ_THRESH` or `enable` falls.

## Structure
- Package `serial_capture_pkg`: default constants (`WORD_W_DEF=24`, `DEPTH_DEF=64`, `IRQ_THRESH_DEF=32`) and pointer-width helper.
- Sub-module `sync_edge` (2-flop sync + optional rising-edge pulse, async active-low reset), instantiated three times.
- FIFO memory inferred as a register array inside the top.

## Test plan
- LSB_FIRST=1, send 24 bits forming 0xA5C3F0 (bit0 first), one `rd_req` -> `rd_data=0xA5C3F0`, one `rd_valid` pulse, `level` 1 -> 0.
- LSB_FIRST=0, same bit sequence -> bit-reversed word 0x0FC3A5.
- Push 32 words -> `irq` rises one cycle after `level`=32; pop one -> `irq` falls; drop `enable` at level 40 -> `irq` 0 next cycle.
- Push 65 words with no reads -> `level`=64, `overflow`=1, first 64 words read back in order, 65th absent.
- `rd_req` on empty -> `underflow`=1, `rd_data` unchanged; `clear` -> both flags 0, `level` 0.
- Assert `rst_n` low after 10 bits of a word, release, send 24 new bits -> only the new word captured, `level`=1; pop during last-bit push at full -> `level` stays 64, no `overflow`.

Source files
------------

// File: rtl/serial_capture_pkg.sv
// serial_capture_pkg
//   Shared defaults for the serial capture buffer and a helper that sizes
//   the FIFO pointers (one extra bit so full and empty can be told apart).
package serial_capture_pkg;

    localparam int unsigned WORD_W_DEF     = 24;
    localparam int unsigned DEPTH_DEF      = 64;
    localparam int unsigned IRQ_THRESH_DEF = 32;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge
//   Two-flop synchroniser for an asynchronous input. With EDGE=1 a third
//   flop turns the synchronised level into a one-cycle rising-edge pulse.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (all flops clear to 0)
//   d     - asynchronous input
//   q     - EDGE=1: rising-edge pulse; EDGE=0: synchronised level
module sync_edge #(
    parameter bit EDGE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q, s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    if (EDGE) begin : g_edge
        logic s3_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) s3_q <= 1'b0;
            else        s3_q <= s2_q;
        end
        assign q = s2_q & ~s3_q;
    end else begin : g_level
        assign q = s2_q;
    end

endmodule

// File: rtl/serial_capture_fifo.sv
// serial_capture_fifo
//   Samples an externally clocked bit stream in the clk domain, assembles
//   WORD_W-bit words, queues them in a DEPTH-entry FIFO and raises irq when
//   the fill level reaches IRQ_THRESH.
// Ports:
//   clk, rst_n       - system clock, asynchronous active-low reset
//   sclk, sdata      - serial bit clock and data (asynchronous)
//   enable           - capture enable; low discards the partial word, forces irq 0
//   clear            - synchronous flush of FIFO, assembler and error flags
//   rd_req           - asynchronous read strobe, one pop per rising edge
//   rd_data/rd_valid - last popped word / one-cycle pulse on update
//   level            - fill level 0..DEPTH
//   irq              - registered enable && level >= IRQ_THRESH
//   overflow         - sticky: word dropped on full
//   underflow        - sticky: read attempted on empty
module serial_capture_fifo
    import serial_capture_pkg::*;
#(
    parameter int unsigned WORD_W     = WORD_W_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned IRQ_THRESH = IRQ_THRESH_DEF,
    parameter bit          LSB_FIRST  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sclk,
    input  logic                      sdata,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      rd_req,
    output logic [WORD_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      irq,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned AW    = PTR_W - 1;
    localparam int unsigned CNT_W = $clog2(WORD_W);

    logic sclk_rise, sdata_s, rd_rise;

    sync_edge #(.EDGE(1'b1)) u_sync_sclk  (.clk(clk), .rst_n(rst_n), .d(sclk),   .q(sclk_rise));
    // Same two-flop path as sclk so the data bit lines up with the detected edge.
    sync_edge #(.EDGE(1'b0)) u_sync_sdata (.clk(clk), .rst_n(rst_n), .d(sdata),  .q(sdata_s));
    sync_edge #(.EDGE(1'b1)) u_sync_rd    (.clk(clk), .rst_n(rst_n), .d(rd_req), .q(rd_rise));

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  bit_cnt_q, pos;
    logic [WORD_W-1:0] asm_q, asm_word;
    logic [WORD_W-1:0] rd_data_q;
    logic              rd_valid_q, irq_q, overflow_q, underflow_q;
    logic              shift, push, pop, wr_en, full, empty;
    logic [PTR_W-1:0]  level_w;

    always_comb begin
        pos      = LSB_FIRST ? bit_cnt_q : CNT_W'(WORD_W - 1) - bit_cnt_q;
        asm_word = asm_q;
        // Word including the bit arriving now; pushed as-is on the last bit.
        asm_word[pos] = sdata_s;
    end

    assign level_w = wr_ptr_q - rd_ptr_q;
    assign full    = (level_w == PTR_W'(DEPTH));
    assign empty   = (level_w == '0);
    assign shift   = sclk_rise & enable;
    assign push    = shift & (bit_cnt_q == CNT_W'(WORD_W - 1));
    assign pop     = rd_rise & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign wr_en   = push & (~full | pop) & ~clear;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= asm_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            bit_cnt_q   <= '0;
            asm_q       <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            irq_q <= enable && (level_w >= PTR_W'(IRQ_THRESH));
            if (clear) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                bit_cnt_q   <= '0;
                asm_q       <= '0;
                rd_valid_q  <= 1'b0;
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                rd_valid_q <= pop;
                if (pop) begin
                    rd_data_q <= mem[rd_ptr_q[AW-1:0]];
                    rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                end
                if (rd_rise && empty)       underflow_q <= 1'b1;
                if (wr_en)                  wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
                if (push && full && !pop)   overflow_q  <= 1'b1;
                if (!enable) begin
                    bit_cnt_q <= '0;
                    asm_q     <= '0;
                end else if (shift) begin
                    if (push) begin
                        bit_cnt_q <= '0;
                        asm_q     <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        asm_q     <= asm_word;
                    end
                end
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign level     = level_w;
    assign irq       = irq_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_serial_capture_fifo.sv
// tb_serial_capture_fifo
//   Drives two instances (LSB-first and MSB-first) with the same serial
//   stream and compares both against a queue-based reference model.
module tb_serial_capture_fifo;

    localparam int W = 24;
    localparam int D = 64;
    localparam int T = 32;

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, sdata = 1'b0;
    logic enable = 1'b0, clear = 1'b0, rd_req = 1'b0;
    logic [W-1:0] rd_data0, rd_data1;
    logic [6:0]   level0, level1;
    logic rd_valid0, rd_valid1, irq0, irq1, ovf0, ovf1, udf0, udf1;

    always #5 clk = ~clk;

    serial_capture_fifo #(.WORD_W(W), .DEPTH(D), .IRQ_THRESH(T), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdata(sdata), .enable(enable),
        .clear(clear), .rd_req(rd_req), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .level(level0), .irq(irq0), .overflow(ovf0), .underflow(udf0));

    serial_capture_fifo #(.WORD_W(W), .DEPTH(D), .IRQ_THRESH(T), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdata(sdata), .enable(enable),
        .clear(clear), .rd_req(rd_req), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .level(level1), .irq(irq1), .overflow(ovf1), .underflow(udf1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: received bits collected in order, words in queues.
    bit           bits[$];
    logic [W-1:0] q_lsb[$], q_msb[$];
    logic [W-1:0] m_rd0 = '0, m_rd1 = '0;
    bit           m_ovf = 0, m_udf = 0;

    task automatic model_read(output bit ok);
        if (q_lsb.size() > 0) begin
            m_rd0 = q_lsb.pop_front();
            m_rd1 = q_msb.pop_front();
            ok = 1;
        end else begin
            m_udf = 1;
            ok = 0;
        end
    endtask

    task automatic model_bit(input bit b);
        logic [W-1:0] wl, wm;
        if (!enable) return;
        bits.push_back(b);
        if (bits.size() == W) begin
            wl = '0;
            wm = '0;
            for (int i = 0; i < W; i++) begin
                wl = wl + (W'(bits[i]) << i);
                wm = wm + (W'(bits[i]) << (W - 1 - i));
            end
            bits.delete();
            if (q_lsb.size() < D) begin
                q_lsb.push_back(wl);
                q_msb.push_back(wm);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic model_flush();
        bits.delete();
        q_lsb.delete();
        q_msb.delete();
        m_ovf = 0;
        m_udf = 0;
    endtask

    // First-edge timestamps for the level -> irq latency check.
    int  cyc = 0, t_lvl = -1, t_irq = -1;
    bit  arm = 0;
    logic irq_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (arm && t_lvl < 0 && level0 >= 7'(T)) t_lvl = cyc;
        if (arm && t_irq < 0 && irq0 && !irq_prev) t_irq = cyc;
        irq_prev = irq0;
    end

    task automatic send_bit(input bit b, input bit rd);
        bit ok;
        @(negedge clk);
        sdata = b;
        repeat (2) @(negedge clk);
        sclk   = 1'b1;
        rd_req = rd;
        repeat (4) @(negedge clk);
        sclk   = 1'b0;
        rd_req = 1'b0;
        if (rd) model_read(ok);
        model_bit(b);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) send_bit(w[i], 1'b0);
    endtask

    task automatic do_read(input string tag);
        int pulses;
        bit ok;
        pulses = 0;
        @(negedge clk);
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_valid0) pulses++;
            if (i == 3) rd_req = 1'b0;
        end
        model_read(ok);
        check({tag, "_pulses"}, pulses, ok ? 1 : 0);
        check({tag, "_data0"}, rd_data0, m_rd0);
        check({tag, "_data1"}, rd_data1, m_rd1);
        check({tag, "_level"}, level0, q_lsb.size());
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level0"}, level0, q_lsb.size());
        check({tag, "_level1"}, level1, q_msb.size());
        check({tag, "_ovf0"}, ovf0, m_ovf);
        check({tag, "_udf0"}, udf0, m_udf);
        check({tag, "_ovf1"}, ovf1, m_ovf);
        check({tag, "_udf1"}, udf1, m_udf);
        check({tag, "_irq0"}, irq0, (enable && q_lsb.size() >= T) ? 1 : 0);
        check({tag, "_irq1"}, irq1, (enable && q_msb.size() >= T) ? 1 : 0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_flush();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rd_data", rd_data0, 0);
        check("rst_rd_valid", rd_valid0, 0);
        check("rst_level", level0, 0);
        check("rst_irq", irq0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_udf", udf0, 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Known word in both bit orders.
        send_word(24'hA5C3F0);
        check_state("known");
        do_read("known_rd");
        check("known_lsb", rd_data0, 24'hA5C3F0);
        check("known_msb", rd_data1, 24'h0FC3A5);

        // Partial word discarded by dropping enable.
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0);
        @(negedge clk);
        enable = 1'b0;
        bits.delete();
        repeat (2) @(negedge clk);
        enable = 1'b1;
        send_word(W'($urandom));
        check_state("discard");
        do_read("discard_rd");

        // Threshold interrupt.
        arm = 1;
        for (int k = 0; k < T; k++) begin
            send_word(W'($urandom));
            if (k == T - 2) check_state("below_thr");
        end
        check_state("at_thr");
        check("irq_lag", t_irq - t_lvl, 1);
        arm = 0;
        do_read("thr_pop");
        check_state("thr_pop");
        for (int k = 0; k < 9; k++) send_word(W'($urandom));
        check_state("lvl40");
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("irq_en_drop", irq0, 0);
        check_state("en_low");
        enable = 1'b1;

        // Overflow: 65 words, read back 64, then one read on empty.
        do_clear();
        check_state("clr1");
        for (int k = 0; k < D + 1; k++) send_word(W'($urandom));
        check_state("ovf");
        for (int k = 0; k < D; k++) do_read("drain");
        do_read("empty_rd");
        check_state("udf");
        do_clear();
        check_state("clr2");

        // Reset in the middle of a word.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        model_flush();
        m_rd0 = '0;
        m_rd1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_state("midrst");
        send_word(W'($urandom));
        check_state("midrst_word");
        do_read("midrst_rd");

        // Pop coinciding with the last-bit push at full.
        for (int k = 0; k < D; k++) send_word(W'($urandom));
        check_state("full");
        for (int i = 0; i < W - 1; i++) send_bit(1'($urandom), 1'b0);
        send_bit(1'($urandom), 1'b1);
        check_state("full_pushpop");
        check("full_pushpop_data", rd_data0, m_rd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
